// File: rtl/qam16_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : qam16_pkg
// Brief    : Shared constants for the 16-QAM symbol error counter: symbol
//            width, per-rail level codes, FSM state encoding, popcount helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package qam16_pkg;

   localparam int SYM_W = 4;

   // Per-rail level codes, identical for I and Q
   localparam logic [1:0] LVL_M3 = 2'b00;   // -3a
   localparam logic [1:0] LVL_M1 = 2'b01;   // -a
   localparam logic [1:0] LVL_P1 = 2'b10;   // +a
   localparam logic [1:0] LVL_P3 = 2'b11;   // +3a

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ARMED = 2'd1,
      COUNT = 2'd2
   } state_e;

   // Number of set bits in a 4-bit symbol difference (0..4)
   function automatic logic [2:0] popcount4(input logic [SYM_W-1:0] v);
      logic [2:0] pc;
      pc = '0;
      for (int i = 0; i < SYM_W; i++) begin
         pc = pc + {2'b00, v[i]};
      end
      return pc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qam16_slicer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : qam16_slicer
// Brief    : Single-rail 4-level decision slicer. Compares a signed sample
//            against +/-thresh and zero; ties resolve to the upper level.
//            Decision is registered on the symbol enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module qam16_slicer
   import qam16_pkg::*;
#(
   parameter int DATA_W = 18
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sym_clk_en,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] thresh,
   output logic [1:0]               level
);

   // One extra bit so that negating the threshold can never overflow
   logic signed [DATA_W:0] x_ext;
   logic signed [DATA_W:0] pos_thr;
   logic signed [DATA_W:0] neg_thr;
   logic [1:0]             level_d;
   logic [1:0]             level_q;

   assign x_ext   = {x[DATA_W-1], x};
   assign pos_thr = {thresh[DATA_W-1], thresh};
   assign neg_thr = -pos_thr;

   // Decision regions; equality falls into the upper region
   always_comb begin
      level_d = level_q;
      if (sym_clk_en) begin
         if (x_ext < neg_thr) begin
            level_d = LVL_M3;
         end else if (x_ext < 0) begin
            level_d = LVL_M1;
         end else if (x_ext < pos_thr) begin
            level_d = LVL_P1;
         end else begin
            level_d = LVL_P3;
         end
      end
   end

   // Decision register, one symbol of latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= LVL_M3;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/qam16_ser_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : qam16_ser_counter
// Brief    : 16-QAM receive performance monitor. Slices I/Q samples, compares
//            against a delayed copy of the transmit symbol stream and counts
//            symbol and bit errors over windows bounded by window_start.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module qam16_ser_counter
   import qam16_pkg::*;
#(
   parameter int DATA_W    = 18,
   parameter int DELAY_MAX = 64,
   parameter int CNT_W     = 22
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sym_clk_en,
   input  logic [SYM_W-1:0]             ref_sym,
   input  logic signed [DATA_W-1:0]     rx_inphase,
   input  logic signed [DATA_W-1:0]     rx_quad,
   input  logic signed [DATA_W-1:0]     thresh,
   input  logic [$clog2(DELAY_MAX)-1:0] delay,
   input  logic                         window_start,
   output logic [CNT_W-1:0]             sym_count,
   output logic [CNT_W-1:0]             sym_err_count,
   output logic [CNT_W+1:0]             bit_err_count,
   output logic                         result_valid,
   output logic                         locked
);

   localparam int DLY_W = $clog2(DELAY_MAX);

   logic [1:0]       lvl_inph;
   logic [1:0]       lvl_quad;
   logic [SYM_W-1:0] rx_sym;
   logic [SYM_W-1:0] ref_tap;
   logic [SYM_W-1:0] sym_diff;
   logic             sym_err;
   logic [2:0]       bit_errs;

   logic [SYM_W-1:0] dline_d [DELAY_MAX];
   logic [SYM_W-1:0] dline_q [DELAY_MAX];
   state_e           state_d, state_q;
   logic [DLY_W-1:0] fill_d, fill_q;
   logic [DLY_W-1:0] delay_d, delay_q;
   logic [CNT_W-1:0] acc_cnt_d, acc_cnt_q;
   logic [CNT_W-1:0] acc_serr_d, acc_serr_q;
   logic [CNT_W+1:0] acc_berr_d, acc_berr_q;
   logic [CNT_W-1:0] sym_count_d, sym_count_q;
   logic [CNT_W-1:0] sym_err_count_d, sym_err_count_q;
   logic [CNT_W+1:0] bit_err_count_d, bit_err_count_q;
   logic             result_valid_d, result_valid_q;
   logic             locked_d, locked_q;

   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] serr_inc;
   logic [CNT_W+2:0] berr_sum;
   logic [CNT_W+1:0] berr_inc;

   qam16_slicer #(.DATA_W(DATA_W)) u_slicer_i (
      .clk        (clk),
      .reset_n    (reset_n),
      .sym_clk_en (sym_clk_en),
      .x          (rx_inphase),
      .thresh     (thresh),
      .level      (lvl_inph)
   );

   qam16_slicer #(.DATA_W(DATA_W)) u_slicer_q (
      .clk        (clk),
      .reset_n    (reset_n),
      .sym_clk_en (sym_clk_en),
      .x          (rx_quad),
      .thresh     (thresh),
      .level      (lvl_quad)
   );

   // Both sides of the compare are registered: slice of symbol n vs ref n-delay
   assign rx_sym   = {lvl_inph, lvl_quad};
   assign ref_tap  = dline_q[delay_q];
   assign sym_diff = rx_sym ^ ref_tap;
   assign sym_err  = |sym_diff;
   assign bit_errs = popcount4(sym_diff);

   // Saturating increments; counters stick at all-ones instead of wrapping
   assign cnt_inc  = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);
   assign serr_inc = (sym_err && !(&acc_serr_q)) ? acc_serr_q + CNT_W'(1) : acc_serr_q;
   assign berr_sum = {1'b0, acc_berr_q} + (CNT_W+3)'(bit_errs);
   assign berr_inc = berr_sum[CNT_W+2] ? '1 : berr_sum[CNT_W+1:0];

   // Reference delay line, window FSM and accumulators
   always_comb begin
      dline_d         = dline_q;
      state_d         = state_q;
      fill_d          = fill_q;
      delay_d         = delay_q;
      acc_cnt_d       = acc_cnt_q;
      acc_serr_d      = acc_serr_q;
      acc_berr_d      = acc_berr_q;
      sym_count_d     = sym_count_q;
      sym_err_count_d = sym_err_count_q;
      bit_err_count_d = bit_err_count_q;
      result_valid_d  = 1'b0;
      locked_d        = (state_q == COUNT);

      if (sym_clk_en) begin
         dline_d[0] = ref_sym;
         for (int i = 1; i < DELAY_MAX; i++) begin
            dline_d[i] = dline_q[i-1];
         end

         case (state_q)
            // Wait until the line holds delay+1 fresh symbols; the live delay
            // input is the one that gets latched on the way out
            FILL: begin
               if (fill_q >= delay) begin
                  state_d = ARMED;
                  delay_d = delay;
               end else begin
                  fill_d = fill_q + DLY_W'(1);
               end
            end
            ARMED: begin
               if (window_start) begin
                  if (delay != delay_q) begin
                     state_d = FILL;
                     fill_d  = '0;
                  end else begin
                     state_d    = COUNT;
                     acc_cnt_d  = CNT_W'(1);
                     acc_serr_d = CNT_W'(sym_err);
                     acc_berr_d = (CNT_W+2)'(bit_errs);
                  end
               end
            end
            COUNT: begin
               if (window_start) begin
                  if (delay != delay_q) begin
                     // Results of a window measured with a stale delay are dropped
                     state_d = FILL;
                     fill_d  = '0;
                  end else begin
                     sym_count_d     = acc_cnt_q;
                     sym_err_count_d = acc_serr_q;
                     bit_err_count_d = acc_berr_q;
                     result_valid_d  = 1'b1;
                     // The boundary symbol opens the new window
                     acc_cnt_d  = CNT_W'(1);
                     acc_serr_d = CNT_W'(sym_err);
                     acc_berr_d = (CNT_W+2)'(bit_errs);
                  end
               end else begin
                  acc_cnt_d  = cnt_inc;
                  acc_serr_d = serr_inc;
                  acc_berr_d = berr_inc;
               end
            end
            default: begin
               state_d = FILL;
               fill_d  = '0;
            end
         endcase
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DELAY_MAX; i++) begin
            dline_q[i] <= '0;
         end
         state_q         <= FILL;
         fill_q          <= '0;
         delay_q         <= '0;
         acc_cnt_q       <= '0;
         acc_serr_q      <= '0;
         acc_berr_q      <= '0;
         sym_count_q     <= '0;
         sym_err_count_q <= '0;
         bit_err_count_q <= '0;
         result_valid_q  <= 1'b0;
         locked_q        <= 1'b0;
      end else begin
         dline_q         <= dline_d;
         state_q         <= state_d;
         fill_q          <= fill_d;
         delay_q         <= delay_d;
         acc_cnt_q       <= acc_cnt_d;
         acc_serr_q      <= acc_serr_d;
         acc_berr_q      <= acc_berr_d;
         sym_count_q     <= sym_count_d;
         sym_err_count_q <= sym_err_count_d;
         bit_err_count_q <= bit_err_count_d;
         result_valid_q  <= result_valid_d;
         locked_q        <= locked_d;
      end
   end

   assign sym_count     = sym_count_q;
   assign sym_err_count = sym_err_count_q;
   assign bit_err_count = bit_err_count_q;
   assign result_valid  = result_valid_q;
   assign locked        = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_qam16_ser_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_qam16_ser_counter
// Brief    : Randomized scoreboard bench for qam16_ser_counter. A full-width
//            and a 4-bit-counter instance share the same stimulus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_qam16_ser_counter;

   localparam int DATA_W    = 18;
   localparam int DELAY_MAX = 64;
   localparam int CNT_W     = 22;
   localparam int CNT_WS    = 4;
   localparam int A_LVL     = 32768;
   localparam int M_FILL    = 0;
   localparam int M_ARMED   = 1;
   localparam int M_COUNT   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset_n;
   logic                     sym_clk_en;
   logic                     window_start;
   logic [3:0]               ref_sym;
   logic signed [DATA_W-1:0] rx_inphase;
   logic signed [DATA_W-1:0] rx_quad;
   logic signed [DATA_W-1:0] thresh;
   logic [5:0]               delay;

   logic [CNT_W-1:0]  sym_count, sym_err_count;
   logic [CNT_W+1:0]  bit_err_count;
   logic              result_valid, locked;
   logic [CNT_WS-1:0] s_sym_count, s_sym_err_count;
   logic [CNT_WS+1:0] s_bit_err_count;
   logic              s_result_valid, s_locked;

   qam16_ser_counter #(.DATA_W(DATA_W), .DELAY_MAX(DELAY_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .sym_clk_en(sym_clk_en), .ref_sym(ref_sym),
      .rx_inphase(rx_inphase), .rx_quad(rx_quad), .thresh(thresh), .delay(delay),
      .window_start(window_start), .sym_count(sym_count), .sym_err_count(sym_err_count),
      .bit_err_count(bit_err_count), .result_valid(result_valid), .locked(locked)
   );

   qam16_ser_counter #(.DATA_W(DATA_W), .DELAY_MAX(DELAY_MAX), .CNT_W(CNT_WS)) dut_s (
      .clk(clk), .reset_n(reset_n), .sym_clk_en(sym_clk_en), .ref_sym(ref_sym),
      .rx_inphase(rx_inphase), .rx_quad(rx_quad), .thresh(thresh), .delay(delay),
      .window_start(window_start), .sym_count(s_sym_count), .sym_err_count(s_sym_err_count),
      .bit_err_count(s_bit_err_count), .result_valid(s_result_valid), .locked(s_locked)
   );

   typedef struct {
      int cnt;
      int serr;
      int berr;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Phase knobs
   int ph_rx_dly = 0;
   int ph_delay  = 0;
   int ph_flip   = 0;
   int ph_mode   = 0;     // 0 ideal, 1 threshold edges, 2 noisy
   int ph_thresh = 2 * A_LVL;
   int ph_en_pct = 80;

   // Transmit history used only to build the received stream
   int stim_hist [0:16383];
   int stim_n = 0;

   // Reference model: history of decisions and reference symbols since reset
   int hist_sym [0:16383];
   int hist_ref [0:16383];
   int m_n, m_mode, m_fill, m_dq, m_cnt, m_serr, m_berr;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v, input int bits);
      int mx;
      mx = (1 << bits) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic int level_of(input int code);
      case (code)
         0:       return -3 * A_LVL;
         1:       return -A_LVL;
         2:       return A_LVL;
         default: return 3 * A_LVL;
      endcase
   endfunction

   function automatic int slice_of(input int x, input int t);
      if (x < -t) return 0;
      if (x < 0)  return 1;
      if (x < t)  return 2;
      return 3;
   endfunction

   function automatic int popc(input int v);
      int c;
      c = 0;
      for (int i = 0; i < 4; i++) c += (v >> i) & 1;
      return c;
   endfunction

   function automatic int edge_val(input int t);
      case ($urandom_range(0, 6))
         0:       return t;
         1:       return t - 1;
         2:       return 0;
         3:       return -1;
         4:       return -t;
         5:       return -t - 1;
         default: return int'($urandom_range(0, 262142)) - 131071;
      endcase
   endfunction

   task automatic model_reset();
      m_n = 0; m_mode = M_FILL; m_fill = 0; m_dq = 0;
      m_cnt = 0; m_serr = 0; m_berr = 0;
   endtask

   // One accepted symbol: score the previous decision against the reference
   // that was sent delay symbols before it, then apply the window rules.
   task automatic model_step(input int ref_v, input int rx_code, input bit ws, input int dly);
      int p, rs, rr, d, eb, es;
      p  = m_n - 1;
      rs = (p >= 0) ? hist_sym[p] : 0;
      rr = (p - m_dq >= 0) ? hist_ref[p - m_dq] : 0;
      d  = rs ^ rr;
      eb = popc(d);
      es = (d != 0) ? 1 : 0;
      if (m_mode == M_FILL) begin
         if (m_fill >= dly) begin
            m_mode = M_ARMED;
            m_dq   = dly;
         end else begin
            m_fill++;
         end
      end else if (ws) begin
         if (dly != m_dq) begin
            m_mode = M_FILL;
            m_fill = 0;
         end else begin
            if (m_mode == M_COUNT) exp_q.push_back('{m_cnt, m_serr, m_berr});
            m_mode = M_COUNT;
            m_cnt = 1; m_serr = es; m_berr = eb;
         end
      end else if (m_mode == M_COUNT) begin
         m_cnt++; m_serr += es; m_berr += eb;
      end
      hist_sym[m_n] = rx_code;
      hist_ref[m_n] = ref_v;
      m_n++;
   endtask

   // Drive one clock of stimulus, then step past the sampling edge
   task automatic drive(input bit en, input bit ws);
      int r, src, code, vi, vq;
      r    = int'($urandom_range(0, 15));
      code = r;
      if (en) begin
         stim_hist[stim_n] = r;
         src  = stim_n - ph_rx_dly;
         code = (src >= 0) ? stim_hist[src] : 0;
         stim_n++;
      end
      vi = level_of(code >> 2);
      vq = level_of(code & 3);
      if (ph_flip != 0) vi = -vi;
      if (ph_mode == 1) begin
         vi = edge_val(ph_thresh);
         vq = edge_val(ph_thresh);
      end else if (ph_mode == 2) begin
         vi += int'($urandom_range(0, 32768)) - 16384;
         vq += int'($urandom_range(0, 32768)) - 16384;
      end
      sym_clk_en   = en;
      window_start = ws;
      ref_sym      = 4'(r);
      rx_inphase   = 18'(vi);
      rx_quad      = 18'(vq);
      thresh       = 18'(ph_thresh);
      delay        = 6'(ph_delay);
      if (en) model_step(r, slice_of(vi, ph_thresh) * 4 + slice_of(vq, ph_thresh), ws, ph_delay);
      @(posedge clk);
      #1;
   endtask

   // Idle cycles (with ignored window_start pulses) followed by one symbol
   task automatic sym(input bit ws);
      while (int'($urandom_range(0, 99)) >= ph_en_pct) drive(1'b0, ($urandom_range(0, 3) == 0));
      drive(1'b1, ws);
   endtask

   task automatic run_windows(input int nwin, input int lo, input int hi);
      int len;
      for (int w = 0; w < nwin; w++) begin
         len = int'($urandom_range(lo, hi));
         if (ph_mode == 1) ph_thresh = int'($urandom_range(1000, 120000));
         sym(1'b1);
         for (int i = 1; i < len; i++) sym(1'b0);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_sym_count"}, sym_count, 0);
      check({tag, "_sym_err_count"}, sym_err_count, 0);
      check({tag, "_bit_err_count"}, bit_err_count, 0);
      check({tag, "_result_valid"}, result_valid, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_small_sym_count"}, s_sym_count, 0);
      check({tag, "_small_locked"}, s_locked, 0);
   endtask

   // Scoreboard monitor: every result pulse must match the next expectation
   always @(negedge clk) begin
      if (result_valid || s_result_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got result_valid=%0d/%0d, expected no result", result_valid, s_result_valid);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rv_full", result_valid, 1);
            check("rv_small", s_result_valid, 1);
            check("sym_count", sym_count, e.cnt);
            check("sym_err_count", sym_err_count, e.serr);
            check("bit_err_count", bit_err_count, e.berr);
            check("sat_sym_count", s_sym_count, sat(e.cnt, CNT_WS));
            check("sat_sym_err_count", s_sym_err_count, sat(e.serr, CNT_WS));
            check("sat_bit_err_count", s_bit_err_count, sat(e.berr, CNT_WS + 2));
            check("locked_at_result", locked, 1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit, expected end of stimulus");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      reset_n = 1'b0; sym_clk_en = 1'b0; window_start = 1'b0; ref_sym = '0;
      rx_inphase = '0; rx_quad = '0; thresh = 18'(ph_thresh); delay = '0;
      model_reset();
      #2;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Aligned loopback, 1000-symbol windows
      ph_rx_dly = 0; ph_delay = 0; ph_flip = 0; ph_mode = 0;
      repeat (5) sym(1'b0);
      run_windows(3, 1000, 1000);

      // Inverted I rail: every symbol wrong, two bit errors each
      ph_flip = 1; ph_en_pct = 60;
      run_windows(4, 5, 30);

      // Decision boundaries with random thresholds
      ph_flip = 0; ph_mode = 1;
      run_windows(5, 5, 30);
      ph_mode = 0; ph_thresh = 2 * A_LVL;

      // Channel delay of 3 matched by configuration, then a mid-window change
      ph_rx_dly = 3; ph_delay = 3;
      run_windows(4, 20, 40);
      sym(1'b1);
      repeat (10) sym(1'b0);
      ph_delay = 4;
      repeat (10) sym(1'b0);
      run_windows(5, 20, 40);

      // Asynchronous reset in the middle of a counting window
      ph_delay = 3;
      run_windows(3, 10, 20);
      repeat (5) sym(1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      check("locked_before_reset", locked, 1);
      check("pending_before_reset", exp_q.size(), 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Noisy stream after reset, delay 2
      ph_rx_dly = 2; ph_delay = 2; ph_mode = 2;
      run_windows(5, 5, 30);
      repeat (6) drive(1'b0, 1'b0);
      check("leftover_expected", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
